ball_motion_ctrl: RTL and testbench
===================================

BALL_MOTION_CTRL -- requirements
Module: ball_motion_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter BALL_SIZE, default 16, ball edge length in pixels.
REQ-004 SHALL have parameter STEP, default 4, pixels moved per frame per axis.
REQ-005 SHALL have parameter DEB_CYCLES, default 500000, stable cycles required to accept a button level (10 ms at 50 MHz).
REQ-006 SHALL have port sys_clk, input, 1, sole clock, 50 MHz, rising edge.
REQ-007 SHALL have port sys_rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports up, down, left, right, input, 1 each, raw asynchronous buttons, high = pressed.
REQ-009 SHALL have port frame_start, input, 1, one-cycle pulse at start of vertical blanking.
REQ-010 SHALL have ports ball_x and ball_y, output, 10 each, top-left ball coordinate in pixels.
REQ-011 SHALL have port busy, output, 1, high while a position update is in progress.
REQ-012 SHALL have port led, output, 5, led[3:0] = debounced {right,left,down,up}, led[4] = boundary-hit flag.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer, then a per-button counter; debounced level SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any bounce SHALL clear the counter.
REQ-014 SHALL implement FSM IDLE -> CALC -> CLAMP -> IDLE; IDLE leaves only on frame_start; CALC and CLAMP last exactly one cycle each.
REQ-015 SHALL sample the debounced vector in the cycle frame_start is seen in IDLE; later button changes SHALL NOT affect that frame's update.
REQ-016 SHALL arbitrate per axis: up alone -> y-STEP, down alone -> y+STEP, left alone -> x-STEP, right alone -> x+STEP; both or neither on an axis -> no move on that axis; both axes MAY move in one frame.
REQ-017 SHALL compute candidates in CALC with width extended by 2 bits (no wrap-around).
REQ-018 SHALL clamp in CLAMP to x in [0, H_ACTIVE-BALL_SIZE], y in [0, V_ACTIVE-BALL_SIZE]; a decrement below 0 SHALL yield 0, an increment above the maximum SHALL yield the maximum.
REQ-019 SHALL update ball_x/ball_y in the cycle CLAMP is exited, i.e. 3 cycles after the frame_start pulse is sampled; outputs SHALL be stable at all other times.
REQ-020 SHALL set led[4] on any update where clamping occurred or the ball already sat on a bound in a requested direction, and clear it on any update without such an event.
REQ-021 SHALL drive busy high in CALC and CLAMP only; frame_start arriving while busy SHALL be ignored, not queued.

Reset
REQ-022 SHALL, when sys_rst is high at a clock edge, force ball_x=(H_ACTIVE-BALL_SIZE)/2 (312), ball_y=(V_ACTIVE-BALL_SIZE)/2 (232), busy=0, led=0, debounced levels=0, debounce counters=0, state=IDLE.
REQ-023 SHALL, when reset is applied during CALC or CLAMP, abandon the update; the position SHALL be the reset value.
REQ-024 SHALL take priority over frame_start in the same cycle.

Configuration
REQ-025 SHALL compile autonomous motion only when macro BALL_AUTO_BOUNCE_EN is defined.
REQ-026 With BALL_AUTO_BOUNCE_EN: SHALL keep direction bits dir_x, dir_y (reset +x,+y); an axis with no net request SHALL move STEP in its direction bit, which SHALL invert on any clamp on that axis; a button request SHALL override that axis and set its direction bit.
REQ-027 Without BALL_AUTO_BOUNCE_EN: an axis with no net request SHALL hold position; no direction state SHALL exist.

Verification (DEB_CYCLES=4 on bench)
REQ-028 Reset, then no buttons, one frame_start -> ball_x=312, ball_y=232 (macro off); ball_x=316, ball_y=236 (macro on).
REQ-029 right held 10 cycles, then frame_start -> 3 cycles later ball_x=316, busy high exactly 2 cycles, led[3]=1.
REQ-030 right pulsed for 3 cycles -> led[3] stays 0, frame_start yields no x change.
REQ-031 ball_x=2, left held, frame_start -> ball_x=0, led[4]=1; next frame with no request (macro off) -> led[4]=0.
REQ-032 up and down held, left held, frame_start -> ball_y unchanged, ball_x decreases by 4; second frame_start during busy -> ignored.
REQ-033 sys_rst asserted in CLAMP cycle -> next cycle ball_x=312, ball_y=232, busy=0, state IDLE.

Source files
------------

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: debounced 4-button ball mover, one clamped step per frame.
// Optional autonomous bouncing is compiled in with `define BALL_AUTO_BOUNCE_EN.
module ball_motion_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BALL_SIZE  = 16,
    parameter int STEP       = 4,
    parameter int DEB_CYCLES = 500000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       frame_start,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       busy,
    output logic [4:0] led
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic signed [11:0] X_MAX = 12'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] Y_MAX = 12'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] STP   = 12'(STEP);
    localparam logic [9:0] X_RST = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] Y_RST = 10'((V_ACTIVE - BALL_SIZE) / 2);

    typedef enum logic [1:0] {IDLE, CALC, CLAMP} state_t;

    state_t state_q, state_d;
    logic [3:0] sync1_q, sync2_q, deb_q, deb_d, req_q, req_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [9:0] x_q, x_d, y_q, y_d;
    logic signed [11:0] cx_q, cx_d, cy_q, cy_d, dx, dy, idle_dx, idle_dy;
    logic busy_q, busy_d, hit_q, hit_d;
    logic lo_x, hi_x, lo_y, hi_y;

`ifdef BALL_AUTO_BOUNCE_EN
    logic dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    assign idle_dx = dir_x_q ? STP : -STP;
    assign idle_dy = dir_y_q ? STP : -STP;
    always_comb begin
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (state_q == CLAMP) begin
            dir_x_d = (req_q[3] ^ req_q[2]) ? req_q[3] : (lo_x | hi_x) ? ~dir_x_q : dir_x_q;
            dir_y_d = (req_q[1] ^ req_q[0]) ? req_q[1] : (lo_y | hi_y) ? ~dir_y_q : dir_y_q;
        end
    end
`else
    assign idle_dx = '0;
    assign idle_dy = '0;
`endif

    // A level is accepted only after DEB_CYCLES consecutive cycles of disagreement.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CW'(DEB_CYCLES - 1)) deb_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign dx   = (req_q[3] & ~req_q[2]) ? STP : (req_q[2] & ~req_q[3]) ? -STP : idle_dx;
    assign dy   = (req_q[1] & ~req_q[0]) ? STP : (req_q[0] & ~req_q[1]) ? -STP : idle_dy;
    assign lo_x = cx_q[11];
    assign hi_x = cx_q > X_MAX;
    assign lo_y = cy_q[11];
    assign hi_y = cy_q > Y_MAX;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = busy_q;
        hit_d   = hit_q;
        case (state_q)
            IDLE: if (frame_start) begin
                state_d = CALC;
                req_d   = deb_q;
                busy_d  = 1'b1;
            end
            CALC: begin
                cx_d    = $signed({2'b00, x_q}) + dx;
                cy_d    = $signed({2'b00, y_q}) + dy;
                state_d = CLAMP;
            end
            CLAMP: begin
                x_d     = lo_x ? '0 : hi_x ? X_MAX[9:0] : cx_q[9:0];
                y_d     = lo_y ? '0 : hi_y ? Y_MAX[9:0] : cy_q[9:0];
                hit_d   = lo_x | hi_x | lo_y | hi_y;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cnt_q   <= '{default: '0};
            req_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            x_q     <= X_RST;
            y_q     <= Y_RST;
            busy_q  <= 1'b0;
            hit_q   <= 1'b0;
`ifdef BALL_AUTO_BOUNCE_EN
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= {right, left, down, up};
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            hit_q   <= hit_d;
`ifdef BALL_AUTO_BOUNCE_EN
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
`endif
        end
    end

    assign ball_x = x_q;
    assign ball_y = y_q;
    assign busy   = busy_q;
    assign led    = {hit_q, deb_q};
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: directed bench with a scoreboard of expected frame results.
module tb_ball_motion_ctrl;
    localparam int STEP = 4;
    localparam int XMAX = 624;
    localparam int YMAX = 464;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       l;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, frame_start = 1'b0;
    logic [9:0] ball_x, ball_y;
    logic       busy;
    logic [4:0] led;

    int tests = 0;
    int fails = 0;
    int mx = 312, my = 232;
    bit mled = 1'b0, mdx = 1'b1, mdy = 1'b1;
    logic [3:0] btn = '0;
    exp_t q[$];

    always #5 sys_clk = ~sys_clk;

    ball_motion_ctrl #(.DEB_CYCLES(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .up(up), .down(down), .left(left),
        .right(right), .frame_start(frame_start), .ball_x(ball_x), .ball_y(ball_y),
        .busy(busy), .led(led)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        mx = 312; my = 232; mled = 1'b0; mdx = 1'b1; mdy = 1'b1;
        q.delete();
    endtask

    task automatic model(input logic [3:0] b);
        int dx, dy, nx, ny;
        bit rx, ry, hx, hy;
        rx = b[3] ^ b[2];
        ry = b[1] ^ b[0];
        dx = !rx ? 0 : b[3] ? STEP : -STEP;
        dy = !ry ? 0 : b[1] ? STEP : -STEP;
`ifdef BALL_AUTO_BOUNCE_EN
        if (rx) mdx = b[3]; else dx = mdx ? STEP : -STEP;
        if (ry) mdy = b[1]; else dy = mdy ? STEP : -STEP;
`endif
        nx = mx + dx;
        ny = my + dy;
        hx = nx < 0 || nx > XMAX;
        hy = ny < 0 || ny > YMAX;
        mx = nx < 0 ? 0 : nx > XMAX ? XMAX : nx;
        my = ny < 0 ? 0 : ny > YMAX ? YMAX : ny;
`ifdef BALL_AUTO_BOUNCE_EN
        if (!rx && hx) mdx = !mdx;
        if (!ry && hy) mdy = !mdy;
`endif
        mled = hx || hy;
    endtask

    task automatic set_btn(input logic [3:0] b);
        {right, left, down, up} = b;
        btn = b;
        tick(10);
        check("deb_leds", 32'(led[3:0]), 32'(b));
    endtask

    task automatic do_frame(input bit second);
        exp_t e;
        int n;
        logic [9:0] ox, oy;
        ox = ball_x;
        oy = ball_y;
        frame_start = 1'b1;
        model(btn);
        e.x = mx[9:0];
        e.y = my[9:0];
        e.l = mled;
        q.push_back(e);
        tick(1);
        frame_start = second;
        n = 0;
        while (busy === 1'b1 && n < 8) begin
            check("hold_x", 32'(ball_x), 32'(ox));
            check("hold_y", 32'(ball_y), 32'(oy));
            n++;
            tick(1);
            frame_start = 1'b0;
        end
        frame_start = 1'b0;
        check("busy_cycles", 32'(n), 32'd2);
        e = q.pop_front();
        check("ball_x", 32'(ball_x), 32'(e.x));
        check("ball_y", 32'(ball_y), 32'(e.y));
        check("led4", 32'(led[4]), 32'(e.l));
        check("led_deb", 32'(led[3:0]), 32'(btn));
    endtask

    initial begin
        tick(3);
        check("rst_x", 32'(ball_x), 32'd312);
        check("rst_y", 32'(ball_y), 32'd232);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        sys_rst = 1'b0;
        tick(2);
        do_frame(1'b0);
        set_btn(4'b1000);
        do_frame(1'b0);
        set_btn(4'b0000);
        right = 1'b1;
        tick(3);
        right = 1'b0;
        tick(10);
        check("pulse_led3", 32'(led[3]), 32'd0);
        do_frame(1'b0);
        set_btn(4'b0111);
        do_frame(1'b1);
        tick(4);
        check("ignored_busy", 32'(busy), 32'd0);
        check("ignored_x", 32'(ball_x), 32'(mx));
        check("ignored_y", 32'(ball_y), 32'(my));
        set_btn(4'b0100);
        for (int i = 0; i < 200 && mx > 0; i++) do_frame(1'b0);
        check("left_bound", 32'(ball_x), 32'd0);
        do_frame(1'b0);
        set_btn(4'b0000);
        do_frame(1'b0);
        set_btn(4'b1000);
        for (int i = 0; i < 200 && mx < XMAX; i++) do_frame(1'b0);
        do_frame(1'b0);
        set_btn(4'b0010);
        for (int i = 0; i < 200 && my < YMAX; i++) do_frame(1'b0);
        do_frame(1'b0);
        set_btn(4'b0000);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(1);
        check("clamp_busy", 32'(busy), 32'd1);
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        reset_model();
        check("abort_x", 32'(ball_x), 32'd312);
        check("abort_y", 32'(ball_y), 32'd232);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_led", 32'(led), 32'd0);
        tick(4);
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_x", 32'(ball_x), 32'd312);
        do_frame(1'b0);
        sys_rst = 1'b1;
        frame_start = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        frame_start = 1'b0;
        reset_model();
        check("rst_prio_busy", 32'(busy), 32'd0);
        check("rst_prio_x", 32'(ball_x), 32'd312);
        tick(2);
        check("rst_prio_idle", 32'(busy), 32'd0);
        set_btn(4'b0001);
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        check("rst_deb", 32'(led), 32'd0);
        set_btn(4'b0000);
        do_frame(1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
